// File: rtl/int8_zero_skip_pair_packer_if.sv
// Pair stream in, dual-lane beat stream out, for the int8 zero-skip packer.
// The slave view is the packer itself; the master view is whatever feeds and drains it.
interface int8_zero_skip_pair_packer_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_weight;
  logic [7:0] s_act;
  logic       s_last;
  logic       m_ready;
  logic       m_valid0;
  logic       m_valid1;
  logic       m_last0;
  logic       m_last1;
  logic [7:0] m_weight0;
  logic [7:0] m_weight1;
  logic [7:0] m_act0;
  logic [7:0] m_act1;
  logic       m_clear;

  modport slave (
    input  s_valid, s_weight, s_act, s_last, m_ready,
    output s_ready, m_valid0, m_valid1, m_last0, m_last1,
           m_weight0, m_weight1, m_act0, m_act1, m_clear
  );

  modport master (
    output s_valid, s_weight, s_act, s_last, m_ready,
    input  s_ready, m_valid0, m_valid1, m_last0, m_last1,
           m_weight0, m_weight1, m_act0, m_act1, m_clear
  );
endinterface

// File: rtl/int8_zero_skip_pair_packer.sv
// Drops zero-product int8 pairs and packs survivors two per beat for the dual-lane MAC,
// closing each vector with a one-beat accumulator clear and keeping sparsity counters.
module int8_zero_skip_pair_packer #(
  parameter int CNT_WIDTH = 32,
  parameter int SKIP_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  int8_zero_skip_pair_packer_if.slave     bus,
  input  logic                            stats_clr,
  output logic [CNT_WIDTH-1:0]            nz_cnt,
  output logic [CNT_WIDTH-1:0]            skip_cnt,
  output logic [CNT_WIDTH-1:0]            vec_cnt
);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic                 hold_v_r;
  logic [7:0]           hold_w_r;
  logic [7:0]           hold_a_r;
  logic                 valid0_r, valid1_r, last0_r, last1_r, clear_r;
  logic [7:0]           w0_r, a0_r, w1_r, a1_r;
  logic [CNT_WIDTH-1:0] nz_r, skip_r, vec_r;

  logic                 occ_s, out_free_s, ready_s, acc_s, nz_s;
  logic                 n_v0_s, n_v1_s, n_l0_s, n_l1_s, n_clr_s;
  logic [7:0]           n_w0_s, n_a0_s, n_w1_s, n_a1_s;
  logic                 hold_load_s, hold_clr_s, skip_inc_s, vec_inc_s;
  logic [1:0]           nz_inc_s;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, c} + {{(CNT_WIDTH-1){1'b0}}, inc};
    if (sum[CNT_WIDTH]) begin
      sat_add = {CNT_WIDTH{1'b1}};
    end else begin
      sat_add = sum[CNT_WIDTH-1:0];
    end
  endfunction

  assign occ_s      = valid0_r | clear_r;
  assign out_free_s = !occ_s || bus.m_ready;
  // Gated by rst so the source never sees a ready while the block is held in reset.
  assign ready_s    = !rst && (state_r == S_RUN) && out_free_s;
  assign acc_s      = bus.s_valid && ready_s;
  assign nz_s       = (bus.s_weight != 8'd0) && ((SKIP_MODE != 0) || (bus.s_act != 8'd0));

  // Decode the accepted pair (or pending clear) into the next output beat and hold-slot action.
  always_comb begin
    state_nxt_s = state_r;
    n_v0_s      = 1'b0;
    n_v1_s      = 1'b0;
    n_l0_s      = 1'b0;
    n_l1_s      = 1'b0;
    n_clr_s     = 1'b0;
    n_w0_s      = 8'd0;
    n_a0_s      = 8'd0;
    n_w1_s      = 8'd0;
    n_a1_s      = 8'd0;
    hold_load_s = 1'b0;
    hold_clr_s  = 1'b0;
    skip_inc_s  = 1'b0;
    vec_inc_s   = 1'b0;
    nz_inc_s    = 2'd0;
    case (state_r)
      S_CLEAR: begin
        if (out_free_s) begin
          n_clr_s     = 1'b1;
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
      S_RUN: begin
        if (acc_s) begin
          case ({nz_s, bus.s_last, hold_v_r})
            3'b100: hold_load_s = 1'b1;
            3'b101: begin
              {n_v0_s, n_w0_s, n_a0_s} = {1'b1, hold_w_r, hold_a_r};
              {n_v1_s, n_w1_s, n_a1_s} = {1'b1, bus.s_weight, bus.s_act};
              hold_clr_s = 1'b1;
              nz_inc_s   = 2'd2;
            end
            3'b110: begin
              {n_v0_s, n_l0_s, n_w0_s, n_a0_s} = {2'b11, bus.s_weight, bus.s_act};
              nz_inc_s    = 2'd1;
              vec_inc_s   = 1'b1;
              state_nxt_s = S_CLEAR;
            end
            3'b111: begin
              {n_v0_s, n_w0_s, n_a0_s}         = {1'b1, hold_w_r, hold_a_r};
              {n_v1_s, n_l1_s, n_w1_s, n_a1_s} = {2'b11, bus.s_weight, bus.s_act};
              hold_clr_s  = 1'b1;
              nz_inc_s    = 2'd2;
              vec_inc_s   = 1'b1;
              state_nxt_s = S_CLEAR;
            end
            3'b000, 3'b001: skip_inc_s = 1'b1;
            3'b011: begin
              {n_v0_s, n_l0_s, n_w0_s, n_a0_s} = {2'b11, hold_w_r, hold_a_r};
              hold_clr_s  = 1'b1;
              skip_inc_s  = 1'b1;
              nz_inc_s    = 2'd1;
              vec_inc_s   = 1'b1;
              state_nxt_s = S_CLEAR;
            end
            3'b010: begin
              // Everything in this vector was skipped; a (0,0) beat still closes it.
              n_v0_s      = 1'b1;
              n_l0_s      = 1'b1;
              skip_inc_s  = 1'b1;
              vec_inc_s   = 1'b1;
              state_nxt_s = S_CLEAR;
            end
            default: hold_load_s = 1'b0;
          endcase
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      default: state_nxt_s = S_RUN;
    endcase
  end

  // State, hold slot and the registered output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_RUN;
      hold_v_r <= 1'b0;
      hold_w_r <= 8'd0;
      hold_a_r <= 8'd0;
      valid0_r <= 1'b0;
      valid1_r <= 1'b0;
      last0_r  <= 1'b0;
      last1_r  <= 1'b0;
      clear_r  <= 1'b0;
      w0_r     <= 8'd0;
      a0_r     <= 8'd0;
      w1_r     <= 8'd0;
      a1_r     <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      if (hold_load_s) begin
        hold_v_r <= 1'b1;
        hold_w_r <= bus.s_weight;
        hold_a_r <= bus.s_act;
      end else if (hold_clr_s) begin
        hold_v_r <= 1'b0;
      end
      if (out_free_s) begin
        valid0_r <= n_v0_s;
        valid1_r <= n_v1_s;
        last0_r  <= n_l0_s;
        last1_r  <= n_l1_s;
        clear_r  <= n_clr_s;
        w0_r     <= n_w0_s;
        a0_r     <= n_a0_s;
        w1_r     <= n_w1_s;
        a1_r     <= n_a1_s;
      end
    end
  end

  // Saturating sparsity statistics; a same-cycle stats_clr wins over any increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_r   <= '0;
      skip_r <= '0;
      vec_r  <= '0;
    end else if (stats_clr) begin
      nz_r   <= '0;
      skip_r <= '0;
      vec_r  <= '0;
    end else begin
      nz_r   <= sat_add(nz_r, nz_inc_s);
      skip_r <= sat_add(skip_r, {1'b0, skip_inc_s});
      vec_r  <= sat_add(vec_r, {1'b0, vec_inc_s});
    end
  end

  assign bus.s_ready   = ready_s;
  assign bus.m_valid0  = valid0_r;
  assign bus.m_valid1  = valid1_r;
  assign bus.m_last0   = last0_r;
  assign bus.m_last1   = last1_r;
  assign bus.m_clear   = clear_r;
  assign bus.m_weight0 = w0_r;
  assign bus.m_act0    = a0_r;
  assign bus.m_weight1 = w1_r;
  assign bus.m_act1    = a1_r;
  assign nz_cnt        = nz_r;
  assign skip_cnt      = skip_r;
  assign vec_cnt       = vec_r;

endmodule

// File: tb/tb_int8_zero_skip_pair_packer.sv
// Directed bench: dut0 is the default build, dut1 runs SKIP_MODE=1 with 2-bit counters in lockstep.
module tb_int8_zero_skip_pair_packer;
  logic clk = 1'b0;
  logic rst, s_valid, s_last, m_ready, stats_clr;
  logic [7:0] s_weight, s_act;
  logic [31:0] nz0, skip0, vec0;
  logic [1:0]  nz1, skip1, vec1;
  int checks = 0;
  int errors = 0;
  logic [36:0] q0[$];
  logic [36:0] q1[$];

  always #5 clk = ~clk;

  int8_zero_skip_pair_packer_if bus0();
  int8_zero_skip_pair_packer_if bus1();

  assign bus0.s_valid = s_valid;  assign bus1.s_valid = s_valid;
  assign bus0.s_weight = s_weight; assign bus1.s_weight = s_weight;
  assign bus0.s_act = s_act;      assign bus1.s_act = s_act;
  assign bus0.s_last = s_last;    assign bus1.s_last = s_last;
  assign bus0.m_ready = m_ready;  assign bus1.m_ready = m_ready;

  int8_zero_skip_pair_packer #(.CNT_WIDTH(32), .SKIP_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .stats_clr(stats_clr),
    .nz_cnt(nz0), .skip_cnt(skip0), .vec_cnt(vec0));

  int8_zero_skip_pair_packer #(.CNT_WIDTH(2), .SKIP_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .stats_clr(stats_clr),
    .nz_cnt(nz1), .skip_cnt(skip1), .vec_cnt(vec1));

  // beat encoding {clear, v0, v1, l0, l1, w0, a0, w1, a1}
  function automatic logic [36:0] bt(input logic clr, v0, v1, l0, l1,
                                     input logic [7:0] w0, a0, w1, a1);
    return {clr, v0, v1, l0, l1, w0, a0, w1, a1};
  endfunction

  function automatic logic [36:0] obs0();
    return {bus0.m_clear, bus0.m_valid0, bus0.m_valid1, bus0.m_last0, bus0.m_last1,
            bus0.m_weight0, bus0.m_act0, bus0.m_weight1, bus0.m_act1};
  endfunction

  function automatic logic [36:0] obs1();
    return {bus1.m_clear, bus1.m_valid0, bus1.m_valid1, bus1.m_last0, bus1.m_last1,
            bus1.m_weight0, bus1.m_act0, bus1.m_weight1, bus1.m_act1};
  endfunction

  // record every beat that is handed off downstream
  always @(negedge clk) begin
    if (!rst && m_ready) begin
      if (bus0.m_valid0 || bus0.m_clear) q0.push_back(obs0());
      if (bus1.m_valid0 || bus1.m_clear) q1.push_back(obs1());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] w, input logic [7:0] a, input logic l);
    int n;
    s_valid = 1'b1; s_weight = w; s_act = a; s_last = l;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus0.s_ready) break;
    end
    if (n == 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for pair (%0d,%0d)", w, a);
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_weight = 8'd0; s_act = 8'd0;
    m_ready = 1'b1; stats_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus0.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b expected 0", bus0.s_ready); end
    checks++; if (obs0() !== 37'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs0()); end
    checks++; if ({nz0, skip0, vec0} !== 96'd0) begin errors++; $display("FAIL reset_counters: got %0d %0d %0d expected 0 0 0", nz0, skip0, vec0); end
    rst = 1'b0;
    idle(1);
    checks++; if (bus0.s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bus0.s_ready); end
  endtask

  task automatic test_basic();
    logic [36:0] exp[3];
    exp[0] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd5, 8'd2, 8'd6);
    exp[1] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd7, 8'd4, 8'd8);
    exp[2] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    q0.delete(); q1.delete();
    send_pair(8'd1, 8'd5, 1'b0); send_pair(8'd2, 8'd6, 1'b0);
    send_pair(8'd3, 8'd7, 1'b0); send_pair(8'd4, 8'd8, 1'b1);
    idle(3);
    checks++; if (q0.size() !== 3) begin errors++; $display("FAIL basic_beats: got %0d beats expected 3", q0.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [36:0] got;
      got = (i < q0.size()) ? q0[i] : 37'd0;
      checks++; if (got !== exp[i]) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", i, got, exp[i]); end
    end
    checks++; if ({nz0, skip0, vec0} !== {32'd4, 32'd0, 32'd1}) begin errors++; $display("FAIL basic_counters: got %0d %0d %0d expected 4 0 1", nz0, skip0, vec0); end
  endtask

  task automatic test_skip();
    logic [36:0] e0[3];
    logic [36:0] e1[3];
    e0[0] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd2, 8'd2);
    e0[1] = bt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 8'd4, 8'd0, 8'd0);
    e0[2] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    e1[0] = e0[0];
    e1[1] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 8'd0, 8'd4, 8'd4);
    e1[2] = e0[2];
    stats_clr = 1'b1; idle(1); stats_clr = 1'b0;
    checks++; if (nz0 !== 32'd0) begin errors++; $display("FAIL stats_clr: nz_cnt got %0d expected 0", nz0); end
    q0.delete(); q1.delete();
    send_pair(8'd1, 8'd1, 1'b0); send_pair(8'd0, 8'd9, 1'b0); send_pair(8'd2, 8'd2, 1'b0);
    send_pair(8'd3, 8'd0, 1'b0); send_pair(8'd4, 8'd4, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      logic [36:0] g0, g1;
      g0 = (i < q0.size()) ? q0[i] : 37'd0;
      g1 = (i < q1.size()) ? q1[i] : 37'd0;
      checks++; if (g0 !== e0[i]) begin errors++; $display("FAIL skip_beat%0d: got %h expected %h", i, g0, e0[i]); end
      checks++; if (g1 !== e1[i]) begin errors++; $display("FAIL skipmode1_beat%0d: got %h expected %h", i, g1, e1[i]); end
    end
    checks++; if ({nz0, skip0, vec0} !== {32'd3, 32'd2, 32'd1}) begin errors++; $display("FAIL skip_counters: got %0d %0d %0d expected 3 2 1", nz0, skip0, vec0); end
    checks++; if ({nz1, skip1, vec1} !== {2'd3, 2'd1, 2'd1}) begin errors++; $display("FAIL skipmode1_counters_sat: got %0d %0d %0d expected 3 1 1", nz1, skip1, vec1); end
  endtask

  task automatic test_all_skipped();
    logic [36:0] e0[2];
    logic [36:0] e1[2];
    e0[0] = bt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    e0[1] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    e1[0] = bt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7, 8'd0, 8'd0, 8'd0);
    e1[1] = e0[1];
    stats_clr = 1'b1; idle(1); stats_clr = 1'b0;
    q0.delete(); q1.delete();
    send_pair(8'd0, 8'd3, 1'b0); send_pair(8'd0, 8'd0, 1'b0); send_pair(8'd7, 8'd0, 1'b1);
    idle(3);
    checks++; if (q0.size() !== 2) begin errors++; $display("FAIL allskip_beats: got %0d beats expected 2", q0.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [36:0] g0, g1;
      g0 = (i < q0.size()) ? q0[i] : 37'd0;
      g1 = (i < q1.size()) ? q1[i] : 37'd0;
      checks++; if (g0 !== e0[i]) begin errors++; $display("FAIL allskip_beat%0d: got %h expected %h", i, g0, e0[i]); end
      checks++; if (g1 !== e1[i]) begin errors++; $display("FAIL allskip_mode1_beat%0d: got %h expected %h", i, g1, e1[i]); end
    end
    checks++; if ({nz0, skip0, vec0} !== {32'd0, 32'd3, 32'd1}) begin errors++; $display("FAIL allskip_counters: got %0d %0d %0d expected 0 3 1", nz0, skip0, vec0); end
  endtask

  task automatic test_backpressure();
    logic [36:0] e0[3];
    e0[0] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4);
    e0[1] = bt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd6, 8'd0, 8'd0);
    e0[2] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    q0.delete(); q1.delete();
    m_ready = 1'b0;
    send_pair(8'd1, 8'd2, 1'b0); send_pair(8'd3, 8'd4, 1'b0);
    s_valid = 1'b1; s_weight = 8'd5; s_act = 8'd6; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus0.s_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", i, bus0.s_ready); end
      checks++; if (obs0() !== e0[0]) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs0(), e0[0]); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_pair(8'd5, 8'd6, 1'b1);
    idle(3);
    checks++; if (q0.size() !== 3) begin errors++; $display("FAIL stall_beats: got %0d beats expected 3", q0.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [36:0] g0;
      g0 = (i < q0.size()) ? q0[i] : 37'd0;
      checks++; if (g0 !== e0[i]) begin errors++; $display("FAIL stall_beat%0d: got %h expected %h", i, g0, e0[i]); end
    end
  endtask

  task automatic test_skip_mode();
    logic [36:0] e0[4];
    logic [36:0] e1[4];
    e0[0] = bt(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 8'd5, 8'd0, 8'd0);
    e0[1] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    e0[2] = e0[0];
    e0[3] = e0[1];
    e1[0] = e0[0];
    e1[1] = e0[1];
    e1[2] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5, 8'd5, 8'd2, 8'd0);
    e1[3] = e0[1];
    q0.delete(); q1.delete();
    send_pair(8'd5, 8'd5, 1'b0); send_pair(8'd0, 8'd1, 1'b1); idle(3);
    send_pair(8'd5, 8'd5, 1'b0); send_pair(8'd2, 8'd0, 1'b1); idle(3);
    for (int i = 0; i < 4; i++) begin
      logic [36:0] g0, g1;
      g0 = (i < q0.size()) ? q0[i] : 37'd0;
      g1 = (i < q1.size()) ? q1[i] : 37'd0;
      checks++; if (g0 !== e0[i]) begin errors++; $display("FAIL mode0_beat%0d: got %h expected %h", i, g0, e0[i]); end
      checks++; if (g1 !== e1[i]) begin errors++; $display("FAIL mode1_beat%0d: got %h expected %h", i, g1, e1[i]); end
    end
  endtask

  task automatic test_stats();
    stats_clr = 1'b1;
    send_pair(8'd1, 8'd1, 1'b1);
    stats_clr = 1'b0;
    idle(3);
    checks++; if ({nz0, vec0} !== {32'd0, 32'd0}) begin errors++; $display("FAIL clr_priority: got nz %0d vec %0d expected 0 0", nz0, vec0); end
    for (int i = 0; i < 4; i++) begin
      send_pair(8'd1, 8'd1, 1'b1);
      idle(2);
    end
    checks++; if (vec0 !== 32'd4) begin errors++; $display("FAIL vec_count: got %0d expected 4", vec0); end
    checks++; if ({nz1, vec1} !== {2'd3, 2'd3}) begin errors++; $display("FAIL counter_saturate: got nz %0d vec %0d expected 3 3", nz1, vec1); end
  endtask

  task automatic test_reset_mid();
    logic [36:0] e0[2];
    e0[0] = bt(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd2, 8'd2);
    e0[1] = bt(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    send_pair(8'd9, 8'd9, 1'b0); send_pair(8'd8, 8'd8, 1'b0);
    m_ready = 1'b0;
    #2;
    checks++; if (bus0.m_valid1 !== 1'b1) begin errors++; $display("FAIL pre_rst_beat: got valid1 %b expected 1", bus0.m_valid1); end
    rst = 1'b1;
    #1;
    checks++; if (obs0() !== 37'd0) begin errors++; $display("FAIL async_rst_out: got %h expected 0", obs0()); end
    checks++; if (bus0.s_ready !== 1'b0) begin errors++; $display("FAIL async_rst_ready: got %b expected 0", bus0.s_ready); end
    @(posedge clk); #1;
    rst = 1'b0; m_ready = 1'b1;
    send_pair(8'd6, 8'd6, 1'b0);
    rst = 1'b1; #2; rst = 1'b0;
    q0.delete(); q1.delete();
    send_pair(8'd1, 8'd1, 1'b0); send_pair(8'd2, 8'd2, 1'b1);
    idle(3);
    checks++; if (q0.size() !== 2) begin errors++; $display("FAIL rst_hold_beats: got %0d beats expected 2", q0.size()); end
    for (int i = 0; i < 2; i++) begin
      logic [36:0] g0;
      g0 = (i < q0.size()) ? q0[i] : 37'd0;
      checks++; if (g0 !== e0[i]) begin errors++; $display("FAIL rst_hold_beat%0d: got %h expected %h", i, g0, e0[i]); end
    end
    checks++; if (nz0 !== 32'd2) begin errors++; $display("FAIL rst_counters: nz got %0d expected 2", nz0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_all_skipped();
    test_backpressure();
    test_skip_mode();
    test_stats();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
